// File: rtl/ahbl_pkg.sv
// ahbl_pkg: shared AHB-Lite constants and types for the two-master arbiter.
//   - HTRANS encodings (IDLE/BUSY/NONSEQ/SEQ)
//   - HSIZE encodings (BYTE/HALF/WORD)
//   - mst_idx_t: index of one of the two masters
// No ports; imported by the arbiter, its hold sub-module and the testbench.
package ahbl_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [2:0] HSIZE_BYTE = 3'b000;
    localparam logic [2:0] HSIZE_HALF = 3'b001;
    localparam logic [2:0] HSIZE_WORD = 3'b010;

    localparam int NUM_MASTERS = 2;

    typedef logic mst_idx_t;

endpackage

// File: rtl/ahbl_arbiter_2m_if.sv
// ahbl_arbiter_2m_if: bundle of both master-side AHB-Lite ports and the
// shared slave-side port of the two-master arbiter.
//   M0_* / M1_*  : master address/control/write data in, HREADY/HRDATA out
//   S_*          : granted address phase and write data out, HREADY/HRDATA in
// Modports:
//   master : the environment (masters + downstream slave) that drives the
//            arbiter's inputs and observes its outputs
//   slave  : the arbiter itself, which serves the masters' requests
interface ahbl_arbiter_2m_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic [AW-1:0] M0_HADDR;
    logic [1:0]    M0_HTRANS;
    logic [2:0]    M0_HSIZE;
    logic          M0_HWRITE;
    logic [DW-1:0] M0_HWDATA;
    logic          M0_HREADY;
    logic [DW-1:0] M0_HRDATA;

    logic [AW-1:0] M1_HADDR;
    logic [1:0]    M1_HTRANS;
    logic [2:0]    M1_HSIZE;
    logic          M1_HWRITE;
    logic [DW-1:0] M1_HWDATA;
    logic          M1_HREADY;
    logic [DW-1:0] M1_HRDATA;

    logic [AW-1:0] S_HADDR;
    logic [1:0]    S_HTRANS;
    logic [2:0]    S_HSIZE;
    logic          S_HWRITE;
    logic [DW-1:0] S_HWDATA;
    logic          S_HREADY;
    logic [DW-1:0] S_HRDATA;

    modport master (
        output M0_HADDR, M0_HTRANS, M0_HSIZE, M0_HWRITE, M0_HWDATA,
        input  M0_HREADY, M0_HRDATA,
        output M1_HADDR, M1_HTRANS, M1_HSIZE, M1_HWRITE, M1_HWDATA,
        input  M1_HREADY, M1_HRDATA,
        input  S_HADDR, S_HTRANS, S_HSIZE, S_HWRITE, S_HWDATA,
        output S_HREADY, S_HRDATA
    );

    modport slave (
        input  M0_HADDR, M0_HTRANS, M0_HSIZE, M0_HWRITE, M0_HWDATA,
        output M0_HREADY, M0_HRDATA,
        input  M1_HADDR, M1_HTRANS, M1_HSIZE, M1_HWRITE, M1_HWDATA,
        output M1_HREADY, M1_HRDATA,
        output S_HADDR, S_HTRANS, S_HSIZE, S_HWRITE, S_HWDATA,
        input  S_HREADY, S_HRDATA
    );
endinterface

// File: rtl/ahbl_arb_hold.sv
// ahbl_arb_hold: held address-phase register and pending flag for one master.
// A request that could not be forwarded is captured here and replayed to the
// slave later, while the arbiter keeps the master stalled.
// Ports:
//   clk, srst                 clock, synchronous active-high reset
//   capture                   load live_* and set pending
//   clear                     held request was accepted by the slave
//   live_haddr/htrans/hsize/hwrite   master's live address phase
//   pending                   a held request is waiting
//   held_haddr/htrans/hsize/hwrite   the held address phase
module ahbl_arb_hold
    import ahbl_pkg::*;
#(
    parameter int AW = 32
) (
    input  logic          clk,
    input  logic          srst,
    input  logic          capture,
    input  logic          clear,
    input  logic [AW-1:0] live_haddr,
    input  logic [1:0]    live_htrans,
    input  logic [2:0]    live_hsize,
    input  logic          live_hwrite,
    output logic          pending,
    output logic [AW-1:0] held_haddr,
    output logic [1:0]    held_htrans,
    output logic [2:0]    held_hsize,
    output logic          held_hwrite
);

    logic          pending_reg;
    logic [AW-1:0] haddr_reg;
    logic [1:0]    htrans_reg;
    logic [2:0]    hsize_reg;
    logic          hwrite_reg;

    always_ff @(posedge clk) begin
        if (srst) begin
            pending_reg <= 1'b0;
            haddr_reg   <= '0;
            htrans_reg  <= HTRANS_IDLE;
            hsize_reg   <= '0;
            hwrite_reg  <= 1'b0;
        end else if (clear) begin
            pending_reg <= 1'b0;
        end else if (capture) begin
            // capture only happens while not pending (master ready is low
            // while pending), so clear and capture never compete
            pending_reg <= 1'b1;
            haddr_reg   <= live_haddr;
            htrans_reg  <= live_htrans;
            hsize_reg   <= live_hsize;
            hwrite_reg  <= live_hwrite;
        end
    end

    assign pending     = pending_reg;
    assign held_haddr  = haddr_reg;
    assign held_htrans = htrans_reg;
    assign held_hsize  = hsize_reg;
    assign held_hwrite = hwrite_reg;

endmodule

// File: rtl/ahbl_arbiter_2m.sv
// ahbl_arbiter_2m: two-master AHB-Lite arbiter sharing one slave-side bus.
// Uncontended address phases pass straight through; a phase that cannot be
// forwarded is buffered in ahbl_arb_hold and its master is stalled via HREADY.
// Ports:
//   HCLK     clock, all state on the rising edge
//   HRESET   synchronous active-high reset
//   bus      ahbl_arbiter_2m_if.slave: M0_*/M1_* master ports, S_* slave port
// Build option:
//   AHBL_ARB_RR_EN  defined -> round-robin on collisions (non-last-grant wins)
//                   undefined -> fixed priority, M0 over M1
module ahbl_arbiter_2m
    import ahbl_pkg::*;
#(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic               HCLK,
    input  logic               HRESET,
    ahbl_arbiter_2m_if.slave   bus
);

    // master ports gathered into arrays so per-master logic is generated
    logic [AW-1:0] m_haddr  [NUM_MASTERS];
    logic [1:0]    m_htrans [NUM_MASTERS];
    logic [2:0]    m_hsize  [NUM_MASTERS];
    logic          m_hwrite [NUM_MASTERS];
    logic [DW-1:0] m_hwdata [NUM_MASTERS];

    assign m_haddr[0]  = bus.M0_HADDR;
    assign m_htrans[0] = bus.M0_HTRANS;
    assign m_hsize[0]  = bus.M0_HSIZE;
    assign m_hwrite[0] = bus.M0_HWRITE;
    assign m_hwdata[0] = bus.M0_HWDATA;
    assign m_haddr[1]  = bus.M1_HADDR;
    assign m_htrans[1] = bus.M1_HTRANS;
    assign m_hsize[1]  = bus.M1_HSIZE;
    assign m_hwrite[1] = bus.M1_HWRITE;
    assign m_hwdata[1] = bus.M1_HWDATA;

    logic     data_valid_reg;
    mst_idx_t data_owner_reg;
    logic     hold_valid_reg;
    mst_idx_t hold_owner_reg;
    mst_idx_t last_grant_reg;

    logic [NUM_MASTERS-1:0] pending;
    logic [NUM_MASTERS-1:0] ready;
    logic [NUM_MASTERS-1:0] live_req;
    logic [NUM_MASTERS-1:0] req;
    logic [NUM_MASTERS-1:0] capture;
    logic [NUM_MASTERS-1:0] clear;

    logic [AW-1:0] held_haddr  [NUM_MASTERS];
    logic [1:0]    held_htrans [NUM_MASTERS];
    logic [2:0]    held_hsize  [NUM_MASTERS];
    logic          held_hwrite [NUM_MASTERS];

    logic [AW-1:0] src_haddr  [NUM_MASTERS];
    logic [1:0]    src_htrans [NUM_MASTERS];
    logic [2:0]    src_hsize  [NUM_MASTERS];
    logic          src_hwrite [NUM_MASTERS];

    logic     grant_valid;
    mst_idx_t grant;
    logic     accept;

    assign accept = grant_valid && bus.S_HREADY;

    generate
        for (genvar gi = 0; gi < NUM_MASTERS; gi++) begin : g_master
            // a pending master is stalled; the data-phase owner sees the
            // slave's ready; everyone else is free to issue
            assign ready[gi] = pending[gi] ? 1'b0 :
                               (data_valid_reg && (data_owner_reg == mst_idx_t'(gi))) ?
                               bus.S_HREADY : 1'b1;
            assign live_req[gi] = m_htrans[gi][1] && ready[gi];
            assign req[gi]      = pending[gi] || live_req[gi];

            assign src_haddr[gi]  = pending[gi] ? held_haddr[gi]  : m_haddr[gi];
            assign src_htrans[gi] = pending[gi] ? held_htrans[gi] : m_htrans[gi];
            assign src_hsize[gi]  = pending[gi] ? held_hsize[gi]  : m_hsize[gi];
            assign src_hwrite[gi] = pending[gi] ? held_hwrite[gi] : m_hwrite[gi];

            // a live request that does not leave this cycle is buffered,
            // including one granted during a slave wait state
            assign clear[gi]   = accept && (grant == mst_idx_t'(gi));
            assign capture[gi] = live_req[gi] && !clear[gi];

            ahbl_arb_hold #(.AW(AW)) u_hold (
                .clk         (HCLK),
                .srst        (HRESET),
                .capture     (capture[gi]),
                .clear       (clear[gi]),
                .live_haddr  (m_haddr[gi]),
                .live_htrans (m_htrans[gi]),
                .live_hsize  (m_hsize[gi]),
                .live_hwrite (m_hwrite[gi]),
                .pending     (pending[gi]),
                .held_haddr  (held_haddr[gi]),
                .held_htrans (held_htrans[gi]),
                .held_hsize  (held_hsize[gi]),
                .held_hwrite (held_hwrite[gi])
            );
        end
    endgenerate

    // grant selection; a grant issued during wait states is held so the
    // presented address phase stays stable until the slave takes it
    always_comb begin
        grant_valid = 1'b0;
        grant       = 1'b0;
        if (hold_valid_reg) begin
            grant_valid = 1'b1;
            grant       = hold_owner_reg;
        end else begin
`ifdef AHBL_ARB_RR_EN
            if (req[0] && req[1]) begin
                grant_valid = 1'b1;
                grant       = ~last_grant_reg;
            end else if (req[0]) begin
                grant_valid = 1'b1;
                grant       = 1'b0;
            end else if (req[1]) begin
                grant_valid = 1'b1;
                grant       = 1'b1;
            end
`else
            if (req[0]) begin
                grant_valid = 1'b1;
                grant       = 1'b0;
            end else if (req[1]) begin
                grant_valid = 1'b1;
                grant       = 1'b1;
            end
`endif
        end
    end

    always_comb begin
        bus.S_HADDR  = '0;
        bus.S_HTRANS = HTRANS_IDLE;
        bus.S_HSIZE  = '0;
        bus.S_HWRITE = 1'b0;
        if (grant_valid) begin
            bus.S_HADDR  = src_haddr[grant];
            bus.S_HSIZE  = src_hsize[grant];
            bus.S_HWRITE = src_hwrite[grant];
            // a change of owner breaks any burst, so the slave must see NONSEQ
            bus.S_HTRANS = (grant != last_grant_reg) ? HTRANS_NONSEQ : src_htrans[grant];
        end
    end

    assign bus.S_HWDATA  = data_valid_reg ? m_hwdata[data_owner_reg] : '0;
    assign bus.M0_HREADY = ready[0];
    assign bus.M1_HREADY = ready[1];
    assign bus.M0_HRDATA = bus.S_HRDATA;
    assign bus.M1_HRDATA = bus.S_HRDATA;

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            data_valid_reg <= 1'b0;
            data_owner_reg <= 1'b0;
            hold_valid_reg <= 1'b0;
            hold_owner_reg <= 1'b0;
            last_grant_reg <= 1'b1;
        end else begin
            if (accept) begin
                data_valid_reg <= 1'b1;
                data_owner_reg <= grant;
                last_grant_reg <= grant;
            end else if (bus.S_HREADY) begin
                data_valid_reg <= 1'b0;
            end

            if (accept) begin
                hold_valid_reg <= 1'b0;
            end else if (grant_valid && !bus.S_HREADY) begin
                hold_valid_reg <= 1'b1;
                hold_owner_reg <= grant;
            end
        end
    end

endmodule

// File: doc/ahbl_arbiter_2m.md
# ahbl_arbiter_2m

Two-master AHB-Lite arbiter that shares one AHB-Lite slave-side bus (the SoC address decoder/slave mux feeding RAM and the 0x40xxxxxx peripheral space) between master 0 (CPU) and master 1 (DMA/test master). Plain AHB-Lite masters have no bus-request signals, so the block buffers any address phase it cannot forward immediately and stalls that master through its HREADY. Uncontended transfers pass through with zero added latency.

## Interface
- AW, 32, address width
- DW, 32, data width
- HCLK  in  1  clock; all state updates on rising edge
- HRESET  in  1  synchronous, active-high reset
- M0_HADDR / M1_HADDR  in  AW  master address
- M0_HTRANS / M1_HTRANS  in  2  master transfer type
- M0_HSIZE / M1_HSIZE  in  3  master transfer size
- M0_HWRITE / M1_HWRITE  in  1  master write flag
- M0_HWDATA / M1_HWDATA  in  DW  master write data (data phase)
- M0_HREADY / M1_HREADY  out  1  per-master ready
- M0_HRDATA / M1_HRDATA  out  DW  read data; both are S_HRDATA broadcast
- S_HADDR, S_HTRANS, S_HSIZE, S_HWRITE  out  AW/2/3/1  granted address phase
- S_HWDATA  out  DW  data-phase owner's HWDATA
- S_HREADY  in  1  slave-side ready
- S_HRDATA  in  DW  slave-side read data

## Operation
- State: pending[i] with held addr/trans/size/write per master; data_valid and data_owner; hold_valid and hold_owner; last_grant.
- ready_i = 0 if pending[i]; S_HREADY if data_valid && data_owner==i; otherwise 1.
- Request r_i = pending[i] || (M_i_HTRANS[1] && ready_i). Its source is the held register if pending, else the live inputs.
- Grant: hold_owner if hold_valid. Otherwise arbitration among the r_i (see Configuration). No request means no grant.
- S_ address outputs are combinational from the granted source. With no grant: S_HTRANS=IDLE and S_HADDR/S_HSIZE/S_HWRITE = 0.
- S_HTRANS is forced to NONSEQ when the grant differs from last_grant. Bursts are not locked; each beat is arbitrated separately.
- Accept = grant && S_HREADY. On accept:
  - data_owner <= grant, data_valid <= 1
  - last_grant <= grant
  - pending[grant] and hold_valid are cleared
- S_HREADY=1 with no accept: data_valid <= 0.
- S_HREADY=0: data_owner and data_valid are unchanged.
- Grant while S_HREADY=0: hold_valid <= 1 and hold_owner <= grant, so the presented NONSEQ stays stable through wait states.
- Capture: a live request (HTRANS[1] && ready_i) that is not accepted this cycle loads master i's held register and sets pending[i]. This includes a live request that was granted while S_HREADY=0.
- S_HWDATA = HWDATA of data_owner if data_valid, else 0. The stalled master holds HWDATA while its ready_i is low.

## Timing
- Reset values:
  - all outputs: S_HTRANS=IDLE; S_HADDR, S_HSIZE, S_HWRITE, S_HWDATA = 0; M0_HREADY = M1_HREADY = 1
  - pending=0, data_valid=0, hold_valid=0, last_grant=1
- Uncontended: zero-cycle pass-through on the address phase; data phase one cycle later as usual.
- Loser of a collision: the held address appears on S_ the cycle after the winner's accept, provided S_HREADY=1. Its ready_i is low from the cycle after capture until its data phase completes.
- Simultaneous capture of both masters is legal; they drain in arbitration order.
- Reset mid-transfer discards pending and in-flight state. Masters must be reset together with the arbiter.

## Configuration
- AHBL_ARB_RR_EN defined: round-robin arbitration. On a collision, the master that is not last_grant wins, so after reset M0 wins first.
- AHBL_ARB_RR_EN undefined: fixed priority, M0 over M1. last_grant is still kept for the NONSEQ-forcing rule.

## Structure
- Package ahbl_pkg holds:
  - HTRANS constants IDLE/BUSY/NONSEQ/SEQ
  - HSIZE constants BYTE/HALF/WORD
  - the master-index type
- Sub-module ahbl_arb_hold: one master's held-address register plus its pending flag, instantiated twice.

## Test plan
- Fixed-priority collision: M0 NONSEQ read 0x40000001 and M1 NONSEQ write 0x20000002 of 0x00000004 in the same cycle.
  - Required: S_HADDR=0x40000001 first.
  - M1_HREADY low until its data phase; S_HADDR=0x20000002 one cycle later; S_HWDATA=0x00000004 the cycle after that.
- M0 alone: write 0x00000004 of 0xAABBCCDD, size 0, S_HREADY=1.
  - Required: same-cycle S_HADDR/S_HSIZE, S_HWDATA=0xAABBCCDD next cycle, M0_HREADY never low.
- Wait states: slave holds S_HREADY low 2 cycles in M0's data phase while M1 requests 0x00000008.
  - Required: S_HADDR=0x00000008 and S_HTRANS=NONSEQ stable for both cycles; accepted on the S_HREADY rise.
- Round-robin (RR build): both masters request every cycle.
  - Required: grants alternate M0, M1, M0, M1. Without the macro, M1 starves while M0 requests.
- Interleaved SEQ: M1 presents SEQ directly after an M0 grant.
  - Required: S_HTRANS=NONSEQ.
- Reset mid-operation: HRESET asserted for one cycle while M1 is pending.
  - Required: next cycle S_HTRANS=IDLE, both HREADY=1, no transfer for the M1 address.
